// File: rtl/cfg_shift_mux_bank_pkg.sv
// Shared definitions for the configurable shift-loaded mux bank:
// configuration FSM state encodings and a constant clog2 helper.
package cfg_shift_mux_bank_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FULL  = 2'd2
  } cfg_state_e;

  // Ceiling log2; returns 0 for values 0 and 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned pow;
    res = 0;
    pow = 1;
    while (pow < value) begin
      pow = pow << 1;
      res = res + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/cfg_shift_mux_bank_mux.sv
// Purely combinational N:1 lane mux; N is a power of two.
module cfg_mux_n
  import cfg_shift_mux_bank_pkg::*;
#(
  parameter int unsigned N = 16,
  localparam int unsigned SEL_W = clog2(N)
) (
  input  logic [N-1:0]     lanes,
  input  logic [SEL_W-1:0] sel,
  output logic             out
);

  // Route the selected lane straight through.
  always_comb out = lanes[sel];

endmodule

// File: rtl/cfg_shift_mux_bank.sv
// Bank of NUM_MUX configurable N:1 routing muxes. Selects come from an
// active register that is loaded atomically from a serially shifted,
// daisy-chainable shadow register on commit.
module cfg_shift_mux_bank
  import cfg_shift_mux_bank_pkg::*;
#(
  parameter int unsigned NUM_MUX    = 4,
  parameter int unsigned MUX_INPUTS = 16,
  parameter int unsigned OUT_REG    = 0,
  localparam int unsigned SEL_W     = clog2(MUX_INPUTS),
  localparam int unsigned CFG_BITS  = NUM_MUX * SEL_W
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          CFG_DIN,
  input  logic                          CFG_SHIFT,
  input  logic                          CFG_COMMIT,
  input  logic                          CFG_ERR_CLR,
  output logic                          CFG_DOUT,
  output logic                          CFG_FULL,
  output logic                          CFG_BUSY,
  output logic                          CFG_ERR,
  output logic                          CFG_ACK,
  output logic [CFG_BITS-1:0]           SEL_ACTIVE,
  input  logic [NUM_MUX*MUX_INPUTS-1:0] IN,
  output logic [NUM_MUX-1:0]            O
);

  localparam int unsigned CNT_W = clog2(CFG_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CFG_BITS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  cfg_state_e          state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CFG_BITS-1:0] shadow_q, shadow_d;
  logic [CFG_BITS-1:0] active_q, active_d;
  logic                err_q, err_d;
  logic                ack_q, ack_d;
  logic                err_set;
  logic [NUM_MUX-1:0]  o_comb;

  // Next-state logic for the load FSM, shadow/active registers and flags.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    shadow_d = shadow_q;
    active_d = active_q;
    ack_d    = 1'b0;
    err_set  = 1'b0;

    // Shift-then-OR form stays legal when CFG_BITS is 1.
    if (CFG_SHIFT) begin
      shadow_d = (shadow_q << 1) | CFG_BITS'(CFG_DIN);
    end

    unique case (state_q)
      ST_EMPTY: begin
        if (CFG_COMMIT) err_set = 1'b1;
        if (CFG_SHIFT) begin
          count_d = CNT_ONE;
          state_d = (CNT_ONE == CNT_MAX) ? ST_FULL : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (CFG_COMMIT) err_set = 1'b1;
        if (CFG_SHIFT) begin
          count_d = count_q + CNT_ONE;
          if (count_q + CNT_ONE == CNT_MAX) state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (CFG_COMMIT) begin
          // Commit captures the pre-shift shadow; a simultaneous shift
          // starts the next load.
          active_d = shadow_q;
          ack_d    = 1'b1;
          if (CFG_SHIFT) begin
            count_d = CNT_ONE;
            state_d = (CNT_ONE == CNT_MAX) ? ST_FULL : ST_LOAD;
          end else begin
            count_d = '0;
            state_d = ST_EMPTY;
          end
        end else if (CFG_SHIFT) begin
          err_set = 1'b1;
        end
      end
      default: begin
        state_d = ST_EMPTY;
        count_d = '0;
      end
    endcase

    err_d = err_set | (err_q & ~CFG_ERR_CLR);
  end

  // Configuration state registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_EMPTY;
      count_q  <= '0;
      shadow_q <= '0;
      active_q <= '0;
      err_q    <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      err_q    <= err_d;
      ack_q    <= ack_d;
    end
  end

  for (genvar k = 0; k < NUM_MUX; k++) begin : g_mux
    cfg_mux_n #(.N(MUX_INPUTS)) u_mux (
      .lanes (IN[k*MUX_INPUTS +: MUX_INPUTS]),
      .sel   (active_q[k*SEL_W +: SEL_W]),
      .out   (o_comb[k])
    );
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [NUM_MUX-1:0] o_q, o_d;

    // Next value of the registered output stage.
    always_comb o_d = o_comb;

    // Output register, cleared by reset.
    always_ff @(posedge CLK) begin
      if (RST) o_q <= '0;
      else     o_q <= o_d;
    end

    assign O = o_q;
  end else begin : g_ocomb
    assign O = o_comb;
  end

  assign CFG_DOUT   = shadow_q[CFG_BITS-1];
  assign CFG_FULL   = (state_q == ST_FULL);
  assign CFG_BUSY   = (state_q == ST_LOAD);
  assign CFG_ERR    = err_q;
  assign CFG_ACK    = ack_q;
  assign SEL_ACTIVE = active_q;

endmodule

// File: tb/tb_cfg_shift_mux_bank.sv
// Self-checking bench for cfg_shift_mux_bank (4 muxes x 16 lanes).
// Two instances share all inputs: one combinational, one with OUT_REG=1.
module tb_cfg_shift_mux_bank;

  logic        clk = 1'b0;
  logic        rst, din, shift, commit, clr;
  logic [63:0] in_v;
  logic        dout0, full0, busy0, err0, ack0;
  logic        dout1, full1, busy1, err1, ack1;
  logic [15:0] sel0, sel1;
  logic [3:0]  o0, o1;

  int nchk = 0;
  int nerr = 0;

  // Reference model: fresh-bit count instead of FSM states.
  logic [15:0] m_shadow, m_active;
  int          m_fresh;
  logic        m_err, m_ack;
  logic [3:0]  m_oreg;

  always #5 clk = ~clk;

  cfg_shift_mux_bank #(.NUM_MUX(4), .MUX_INPUTS(16), .OUT_REG(0)) dut0 (
    .CLK(clk), .RST(rst), .CFG_DIN(din), .CFG_SHIFT(shift), .CFG_COMMIT(commit),
    .CFG_ERR_CLR(clr), .CFG_DOUT(dout0), .CFG_FULL(full0), .CFG_BUSY(busy0),
    .CFG_ERR(err0), .CFG_ACK(ack0), .SEL_ACTIVE(sel0), .IN(in_v), .O(o0));

  cfg_shift_mux_bank #(.NUM_MUX(4), .MUX_INPUTS(16), .OUT_REG(1)) dut1 (
    .CLK(clk), .RST(rst), .CFG_DIN(din), .CFG_SHIFT(shift), .CFG_COMMIT(commit),
    .CFG_ERR_CLR(clr), .CFG_DOUT(dout1), .CFG_FULL(full1), .CFG_BUSY(busy1),
    .CFG_ERR(err1), .CFG_ACK(ack1), .SEL_ACTIVE(sel1), .IN(in_v), .O(o1));

  function automatic logic [3:0] mux_model(input logic [63:0] inp, input logic [15:0] act);
    logic [3:0] r;
    for (int k = 0; k < 4; k++) begin
      int unsigned s;
      s = (act >> (4 * k)) & 16'hF;
      r[k] = inp[k * 16 + s];
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic was_full, new_err;
    if (rst) begin
      m_shadow = '0; m_active = '0; m_fresh = 0;
      m_err = 1'b0; m_ack = 1'b0; m_oreg = '0;
    end else begin
      m_oreg   = mux_model(in_v, m_active);
      was_full = (m_fresh == 16);
      new_err  = 1'b0;
      m_ack    = 1'b0;
      if (commit) begin
        if (was_full) begin
          m_active = m_shadow;
          m_ack    = 1'b1;
        end else begin
          new_err = 1'b1;
        end
      end
      if (shift) begin
        m_shadow = (m_shadow << 1) | 16'(din);
        if (was_full && !commit) new_err = 1'b1;
      end
      if (commit && was_full) m_fresh = shift ? 1 : 0;
      else if (shift)         m_fresh = (m_fresh < 16) ? m_fresh + 1 : 16;
      m_err = new_err | (m_err & ~clr);
    end
  endtask

  task automatic check_all();
    logic [3:0] exp_o;
    exp_o = mux_model(in_v, m_active);
    chk("O_comb", 64'(o0), 64'(exp_o));
    chk("O_reg", 64'(o1), 64'(m_oreg));
    chk("DOUT", 64'(dout0), 64'(m_shadow[15]));
    chk("FULL", 64'(full0), 64'(m_fresh == 16));
    chk("BUSY", 64'(busy0), 64'(m_fresh > 0 && m_fresh < 16));
    chk("ERR", 64'(err0), 64'(m_err));
    chk("ACK", 64'(ack0), 64'(m_ack));
    chk("SEL_ACTIVE", 64'(sel0), 64'(m_active));
    chk("inst1_cfg", {dout1, full1, busy1, err1, ack1, sel1},
        {dout0, full0, busy0, err0, ack0, sel0});
  endtask

  task automatic step(input logic r, input logic s, input logic d,
                      input logic c, input logic e);
    @(negedge clk);
    rst = r; shift = s; din = d; commit = c; clr = e;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic [63:0] inp;
    logic [3:0]  exp_o;
  } vec_t;

  vec_t vecs[8];
  logic [15:0] cfg_word;
  logic [19:0] pat;

  initial begin
    // Routing vectors under active = 0x3A5C: mux0 lane 12, mux1 lane 5,
    // mux2 lane 10, mux3 lane 3.
    vecs[0] = '{64'h0000_0000_0000_1000, 4'b0001};
    vecs[1] = '{64'h0000_0000_0020_0000, 4'b0010};
    vecs[2] = '{64'h0000_0400_0000_0000, 4'b0100};
    vecs[3] = '{64'h0008_0000_0000_0000, 4'b1000};
    vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 4'b1111};
    vecs[5] = '{64'h0000_0000_0000_0000, 4'b0000};
    vecs[6] = '{64'h0001_0001_0001_0001, 4'b0000};
    vecs[7] = '{64'hFFF7_FBFF_FFDF_EFFF, 4'b0000};

    rst = 1'b1; din = 1'b0; shift = 1'b0; commit = 1'b0; clr = 1'b0;
    in_v = '0;

    // Reset, lane 0 of every mux high.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    in_v = 64'h0001_0001_0001_0001;
    idle();
    chk("reset_O", 64'(o0), 64'hF);
    chk("reset_O_reg", 64'(o1), 64'hF);
    chk("reset_FULL", 64'(full0), 64'h0);
    chk("reset_ERR", 64'(err0), 64'h0);

    // Load 0x3A5C MSB first and commit.
    cfg_word = 16'h3A5C;
    for (int i = 15; i >= 0; i--) begin
      step(1'b0, 1'b1, cfg_word[i], 1'b0, 1'b0);
      chk("load_full_timing", 64'(full0), 64'(i == 0));
    end
    chk("sel_before_commit", 64'(sel0), 64'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("commit_ack", 64'(ack0), 64'h1);
    chk("commit_sel", 64'(sel0), 64'h3A5C);
    chk("mux3_sel", 64'(sel0[15:12]), 64'd3);
    chk("mux0_sel", 64'(sel0[3:0]), 64'd12);
    idle();
    chk("ack_pulse_end", 64'(ack0), 64'h0);

    // Table-driven routing checks.
    for (int v = 0; v < 8; v++) begin
      in_v = vecs[v].inp;
      idle();
      chk("vec_O", 64'(o0), 64'(vecs[v].exp_o));
      chk("vec_O_reg", 64'(o1), 64'(vecs[v].exp_o));
    end

    // Premature commit after 10 bits.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'($urandom_range(1)), 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("early_commit_err", 64'(err0), 64'h1);
    chk("early_commit_sel", 64'(sel0), 64'h3A5C);
    chk("early_commit_busy", 64'(busy0), 64'h1);
    // Clear coinciding with a new error: set wins.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("clr_vs_set", 64'(err0), 64'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("err_clear", 64'(err0), 64'h0);

    // Overrun: 20 bits from empty.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    pat = 20'hB5E39;
    for (int n = 1; n <= 20; n++) begin
      step(1'b0, 1'b1, pat[20 - n], 1'b0, 1'b0);
      chk("overrun_err", 64'(err0), 64'(n >= 17));
      if (n >= 16 && n <= 19) chk("chain_dout", 64'(dout0), 64'(pat[20 - (n - 15)]));
    end
    chk("overrun_full", 64'(full0), 64'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Commit together with shift while full.
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("cs_sel", 64'(sel0), 64'(pat[15:0]));
    chk("cs_busy", 64'(busy0), 64'h1);
    chk("cs_full", 64'(full0), 64'h0);
    chk("cs_err", 64'(err0), 64'h0);
    for (int i = 1; i <= 15; i++) begin
      step(1'b0, 1'b1, 1'($urandom_range(1)), 1'b0, 1'b0);
      chk("cs_reload_full", 64'(full0), 64'(i == 15));
    end

    // Reset in mid-load with the registered output.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    in_v = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    in_v = 64'h0001_0000_0001_0001;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_mid_O_reg", 64'(o1), 64'h0);
    chk("rst_mid_busy", 64'(busy0), 64'h0);
    idle();
    chk("rst_mid_lane0", 64'(o1), 64'b1011);
    chk("rst_mid_sel", 64'(sel0), 64'h0);

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      in_v = {$urandom, $urandom};
      step(1'($urandom_range(99) == 0), 1'($urandom_range(9) < 8),
           1'($urandom_range(1)), 1'($urandom_range(15) == 0),
           1'($urandom_range(19) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
